vfm_io_bridge: RTL and testbench

//  Parametrised board-pin <-> core I/O bridge between FPGA pins and the vfmRISC621 core I/O ports.

---
 rtl/vfm_io_bridge.sv | 159 +++++++++++++++
 tb/tb_vfm_io_bridge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vfm_io_bridge.sv
// Board-pin <-> core I/O bridge for vfmRISC621: debounced switch loads into core input
// registers, shadowed core outputs driven onto LEDs in static or auto-scroll mode.
module vfm_io_bridge #(
  parameter int unsigned DATA_W       = 14,
  parameter int unsigned N_IN         = 4,
  parameter int unsigned N_OUT        = 4,
  parameter int unsigned LED_W        = 8,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter int unsigned SCROLL_CYC   = 5000000,
  localparam int unsigned IN_CW       = $clog2(N_IN),
  localparam int unsigned OUT_CW      = $clog2(N_OUT)
) (
  input  logic                    Clock_pin,
  input  logic                    Resetn_pin,
  input  logic [DATA_W-1:0]       sw_data,
  input  logic [IN_CW-1:0]        sw_chan,
  input  logic                    sw_load,
  output logic [N_IN*DATA_W-1:0]  In_bus,
  output logic                    in_write,
  output logic [IN_CW-1:0]        in_chan,
  output logic                    in_err,
  input  logic [N_OUT*DATA_W-1:0] Out_bus,
  input  logic [N_OUT-1:0]        out_wr,
  input  logic                    disp_mode,
  input  logic [OUT_CW-1:0]       led_chan,
  output logic [LED_W-1:0]        LEDS,
  output logic [OUT_CW-1:0]       disp_chan,
  output logic [N_OUT-1:0]        out_new
);

  localparam int unsigned SYNC_W = DATA_W + IN_CW + 1;
  localparam int unsigned DB_CW  = $clog2(DEBOUNCE_CYC);
  localparam int unsigned SC_CW  = $clog2(SCROLL_CYC);

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT_REL} load_state_e;

  logic [SYNC_W-1:0]       sync1_q, sync2_q, prev_q, db_q, db_d;
  logic [DB_CW-1:0]        db_cnt_q, db_cnt_d;
  load_state_e             state_q, state_d;
  logic [N_IN*DATA_W-1:0]  in_bus_q, in_bus_d;
  logic                    in_write_q, in_write_d;
  logic                    in_err_q, in_err_d;
  logic [IN_CW-1:0]        in_chan_q, in_chan_d;
  logic [LED_W-1:0]        shadow_q [N_OUT];
  logic [LED_W-1:0]        shadow_d [N_OUT];
  logic [N_OUT-1:0]        out_new_q, out_new_d;
  logic [OUT_CW-1:0]       disp_chan_q, disp_chan_d;
  logic [SC_CW-1:0]        scroll_q, scroll_d;
  logic [LED_W-1:0]        leds_q, leds_d;

  logic                    db_load;
  logic [IN_CW-1:0]        db_chan;
  logic [DATA_W-1:0]       db_data;
  logic                    unused_out_bits;

  assign {db_load, db_chan, db_data} = db_q;
  // Shadows keep only the LED-visible bits; the upper data bits never reach an output.
  assign unused_out_bits = ^Out_bus;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q != prev_q)
      db_cnt_d = '0;
    else if (db_cnt_q == DB_CW'(DEBOUNCE_CYC - 1))
      db_d = sync2_q;
    else
      db_cnt_d = db_cnt_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    in_bus_d   = in_bus_q;
    in_chan_d  = in_chan_q;
    in_write_d = 1'b0;
    in_err_d   = 1'b0;
    unique case (state_q)
      IDLE:     if (db_load) state_d = CAPTURE;
      CAPTURE: begin
        if (32'(db_chan) < N_IN) begin
          for (int unsigned k = 0; k < N_IN; k++)
            if (db_chan == IN_CW'(k)) in_bus_d[k*DATA_W +: DATA_W] = db_data;
          in_chan_d  = db_chan;
          in_write_d = 1'b1;
        end else begin
          in_err_d = 1'b1;
        end
        state_d = WAIT_REL;
      end
      WAIT_REL: if (!db_load) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < N_OUT; k++) begin
      shadow_d[k]  = out_wr[k] ? Out_bus[k*DATA_W +: LED_W] : shadow_q[k];
      // A write in the same cycle the channel is shown keeps the flag set.
      out_new_d[k] = out_wr[k] | (out_new_q[k] & (disp_chan_q != OUT_CW'(k)));
    end
    leds_d      = (32'(disp_chan_q) < N_OUT) ? shadow_q[disp_chan_q] : '0;
    disp_chan_d = disp_chan_q;
    scroll_d    = scroll_q;
    if (!disp_mode) begin
      disp_chan_d = led_chan;
      scroll_d    = '0;
    end else if (scroll_q == SC_CW'(SCROLL_CYC - 1)) begin
      scroll_d    = '0;
      disp_chan_d = (32'(disp_chan_q) >= N_OUT - 1) ? '0 : disp_chan_q + 1'b1;
    end else begin
      scroll_d = scroll_q + 1'b1;
    end
  end

  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      db_q        <= '0;
      db_cnt_q    <= '0;
      state_q     <= IDLE;
      in_bus_q    <= '0;
      in_write_q  <= 1'b0;
      in_err_q    <= 1'b0;
      in_chan_q   <= '0;
      for (int unsigned k = 0; k < N_OUT; k++) shadow_q[k] <= '0;
      out_new_q   <= '0;
      disp_chan_q <= '0;
      scroll_q    <= '0;
      leds_q      <= '0;
    end else begin
      sync1_q     <= {sw_load, sw_chan, sw_data};
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      db_q        <= db_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      in_bus_q    <= in_bus_d;
      in_write_q  <= in_write_d;
      in_err_q    <= in_err_d;
      in_chan_q   <= in_chan_d;
      for (int unsigned k = 0; k < N_OUT; k++) shadow_q[k] <= shadow_d[k];
      out_new_q   <= out_new_d;
      disp_chan_q <= disp_chan_d;
      scroll_q    <= scroll_d;
      leds_q      <= leds_d;
    end
  end

  assign In_bus    = in_bus_q;
  assign in_write  = in_write_q;
  assign in_chan   = in_chan_q;
  assign in_err    = in_err_q;
  assign LEDS      = leds_q;
  assign disp_chan = disp_chan_q;
  assign out_new   = out_new_q;

endmodule

// File: tb/tb_vfm_io_bridge.sv
// Bench for vfm_io_bridge: directed and random loads/display traffic checked against
// a cycle-level behavioural model; a second instance with N_IN=3 covers out-of-range loads.
module tb_vfm_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [13:0] sw_data = '0;
  logic [1:0]  sw_chan = '0;
  logic        sw_load = 1'b0;
  logic [55:0] o_bus = '0;
  logic [3:0]  o_wr = '0;
  logic        mode = 1'b0;
  logic [1:0]  led_chan = '0;

  logic [55:0] in_bus0;
  logic [41:0] in_bus1;
  logic        in_write0, in_write1, in_err0, in_err1;
  logic [1:0]  in_chan0, in_chan1, disp0, disp1;
  logic [7:0]  leds0, leds1;
  logic [3:0]  new0, new1;

  always #5 clk = ~clk;

  vfm_io_bridge #(.DATA_W(14), .N_IN(4), .N_OUT(4), .LED_W(8), .DEBOUNCE_CYC(4), .SCROLL_CYC(8)) dut0 (
    .Clock_pin(clk), .Resetn_pin(rst_n), .sw_data(sw_data), .sw_chan(sw_chan), .sw_load(sw_load),
    .In_bus(in_bus0), .in_write(in_write0), .in_chan(in_chan0), .in_err(in_err0),
    .Out_bus(o_bus), .out_wr(o_wr), .disp_mode(mode), .led_chan(led_chan),
    .LEDS(leds0), .disp_chan(disp0), .out_new(new0));

  vfm_io_bridge #(.DATA_W(14), .N_IN(3), .N_OUT(4), .LED_W(8), .DEBOUNCE_CYC(4), .SCROLL_CYC(8)) dut1 (
    .Clock_pin(clk), .Resetn_pin(rst_n), .sw_data(sw_data), .sw_chan(sw_chan), .sw_load(sw_load),
    .In_bus(in_bus1), .in_write(in_write1), .in_chan(in_chan1), .in_err(in_err1),
    .Out_bus(o_bus), .out_wr(o_wr), .disp_mode(mode), .led_chan(led_chan),
    .LEDS(leds1), .disp_chan(disp1), .out_new(new1));

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_w0 = 0, n_w1 = 0, n_e0 = 0, n_e1 = 0;

  always @(negedge clk) begin
    if (in_write0) n_w0++;
    if (in_write1) n_w1++;
    if (in_err0)   n_e0++;
    if (in_err1)   n_e1++;
  end

  // Behavioural model state
  logic [7:0]  m_sh [4];
  int          m_disp, m_tmr;
  logic [7:0]  m_leds;
  logic [3:0]  m_new;
  logic [13:0] e_in0 [4];
  logic [13:0] e_in1 [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) m_sh[k] = '0;
    m_disp = 0; m_tmr = 0; m_leds = '0; m_new = '0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    logic [3:0] nn;
    @(posedge clk);
    m_leds = (m_disp < 4) ? m_sh[m_disp] : 8'h00;
    for (int k = 0; k < 4; k++) nn[k] = o_wr[k] | (m_new[k] & (m_disp != k));
    m_new = nn;
    for (int k = 0; k < 4; k++) if (o_wr[k]) m_sh[k] = o_bus[k*14 +: 8];
    if (!mode) begin
      m_disp = int'(led_chan); m_tmr = 0;
    end else if (m_tmr == 7) begin
      m_tmr = 0; m_disp = (m_disp + 1) % 4;
    end else begin
      m_tmr++;
    end
    #1;
    chk("leds", leds0, m_leds);
    chk("disp_chan", disp0, m_disp);
    chk("out_new", new0, m_new);
  endtask

  task automatic do_load(input logic [13:0] d, input logic [1:0] c, input int hold,
                         output int dw0, output int dw1, output int de0, output int de1);
    int s0, s1, s2, s3;
    sw_data = d; sw_chan = c;
    repeat (10) @(posedge clk);
    #1;
    s0 = n_w0; s1 = n_w1; s2 = n_e0; s3 = n_e1;
    sw_load = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    sw_load = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    dw0 = n_w0 - s0; dw1 = n_w1 - s1; de0 = n_e0 - s2; de1 = n_e1 - s3;
  endtask

  task automatic check_in();
    for (int k = 0; k < 4; k++) chk("in_bus0", in_bus0[k*14 +: 14], e_in0[k]);
    for (int k = 0; k < 3; k++) chk("in_bus1", in_bus1[k*14 +: 14], e_in1[k]);
  endtask

  initial begin
    int dw0, dw1, de0, de1, s0;
    logic [13:0] rd;
    logic [1:0]  rc;
    logic [7:0]  scroll_exp [5];
    for (int k = 0; k < 4; k++) e_in0[k] = '0;
    for (int k = 0; k < 3; k++) e_in1[k] = '0;
    model_clear();

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_bus", in_bus0, 0);
    chk("rst_in_write", in_write0, 0);
    chk("rst_in_chan", in_chan0, 0);
    chk("rst_in_err", in_err0, 0);
    chk("rst_leds", leds0, 0);
    chk("rst_disp", disp0, 0);
    chk("rst_out_new", new0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Clean held press: exactly one load
    do_load(14'h1A5, 2'd2, 20, dw0, dw1, de0, de1);
    e_in0[2] = 14'h1A5; e_in1[2] = 14'h1A5;
    chk("load_pulses0", dw0, 1);
    chk("load_pulses1", dw1, 1);
    chk("load_err1", de1, 0);
    chk("load_chan", in_chan0, 2);
    check_in();

    // Short bounce: rejected
    do_load(14'h3FF, 2'd1, 2, dw0, dw1, de0, de1);
    chk("bounce_pulses", dw0, 0);
    chk("bounce_err", de1, 0);
    check_in();

    // Channel 3: valid for N_IN=4, out of range for N_IN=3
    do_load(14'h2B4, 2'd3, 20, dw0, dw1, de0, de1);
    e_in0[3] = 14'h2B4;
    chk("oor_pulses0", dw0, 1);
    chk("oor_err0", de0, 0);
    chk("oor_chan0", in_chan0, 3);
    chk("oor_pulses1", dw1, 0);
    chk("oor_err1", de1, 1);
    chk("oor_chan1", in_chan1, 2);
    check_in();

    // Random loads
    for (int i = 0; i < 6; i++) begin
      rd = 14'($urandom);
      rc = 2'($urandom_range(0, 3));
      do_load(rd, rc, $urandom_range(10, 25), dw0, dw1, de0, de1);
      e_in0[rc] = rd;
      if (rc < 3) e_in1[rc] = rd;
      chk("rnd_pulses0", dw0, 1);
      chk("rnd_pulses1", dw1, (rc < 3) ? 1 : 0);
      chk("rnd_err1", de1, (rc < 3) ? 0 : 1);
      chk("rnd_chan0", in_chan0, rc);
      check_in();
    end

    // Static display
    o_bus[14 +: 14] = 14'h0C3; o_wr = 4'b0010; led_chan = 2'd1;
    tick();
    o_wr = '0;
    tick();
    chk("static_leds", leds0, 8'hC3);
    chk("static_new_cleared", new0[1], 0);

    // Auto-scroll
    o_bus = {6'h15, 8'h44, 6'h2A, 8'h33, 6'h3F, 8'h22, 6'h01, 8'h11};
    scroll_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    o_wr = 4'hF; led_chan = 2'd0;
    tick();
    o_wr = '0;
    tick(); tick();
    mode = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      tick();
      if (i % 8 == 4) chk("scroll_leds", leds0, scroll_exp[i / 8]);
      if (i == 12) chk("scroll_new", new0, 4'b1100);
    end

    // Write to the channel being shown
    mode = 1'b0; led_chan = 2'd0;
    tick(); tick();
    o_bus[0 +: 14] = 14'h05A; o_wr = 4'b0001;
    tick();
    chk("simul_new_set", new0[0], 1);
    o_wr = '0;
    tick();
    chk("simul_leds", leds0, 8'h5A);
    chk("simul_new_clr", new0[0], 0);

    // Random display traffic
    for (int i = 0; i < 300; i++) begin
      o_wr = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      o_bus = {$urandom, $urandom};
      led_chan = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      tick();
    end

    // Reset while the load FSM is in CAPTURE
    o_wr = '0; mode = 1'b0; led_chan = '0;
    sw_data = 14'h2AA; sw_chan = 2'd1; sw_load = 1'b0;
    repeat (10) @(posedge clk);
    #1 sw_load = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    chk("pre_rst_no_write", in_write0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_bus", in_bus0, 0);
    chk("mid_rst_in_write", in_write0, 0);
    chk("mid_rst_in_chan", in_chan0, 0);
    chk("mid_rst_in_err", in_err0, 0);
    chk("mid_rst_leds", leds0, 0);
    chk("mid_rst_disp", disp0, 0);
    chk("mid_rst_out_new", new0, 0);
    s0 = n_w0;
    sw_load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_no_write", n_w0 - s0, 0);
    chk("post_rst_in_bus", in_bus0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
